// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared types and constants for the seven-segment scan display back end.
//   state_t     : conversion/handshake FSM states
//   SEG_BLANK   : all segments dark (active-low)
//   SEG_MINUS   : segment g only (minus sign)
//   DIGITS      : number of multiplexed digits
//   bcd_to_seg(): BCD digit 0-9 to active-low glyph, seg[0]=a .. seg[6]=g
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned VALUE_W = 10;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned ITERS   = VALUE_W;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative 10-bit binary to 4-digit BCD converter (shift-add-3), one bit per
// clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : capture bin and clear the accumulator
//   bin        : unsigned input, 0-1023
//   done       : high during the cycle whose edge performs the last iteration
//   bcd        : {thousands, hundreds, tens, ones}, valid once done has fired
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import seg_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic [VALUE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   adj;
    logic [3:0]         cnt_q;
    logic               run_q;

    // Add 3 to every nibble that is 5 or more, ahead of the shift.
    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = run_q && (cnt_q == 4'(ITERS - 1));
    assign bcd  = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
            bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Display back end: converts a signed 10-bit magnitude to BCD and scans it onto
// four common-anode seven-segment digits.
//   REFRESH_DIV : clocks each digit stays lit (>= 2)
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : one-cycle request to display value/neg (ignored while busy)
//   value, neg  : magnitude 0-1023 and sign (1 = negative)
//   busy        : conversion in progress
//   done        : one-cycle pulse when the new digits become visible
//   an          : active-low digit enables, an[0] rightmost
//   seg         : active-low segments, seg[0]=a .. seg[6]=g
// Build option: SEG_SCAN_BLANK_EN enables leading-zero blanking.
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    input  logic               neg,
    output logic               busy,
    output logic               done,
    output logic [DIGITS-1:0]  an,
    output logic [6:0]         seg
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t           state_q, state_d;
    logic             conv_start, conv_done, latch;
    logic [BCD_W-1:0] conv_bcd;
    logic             neg_q;
    logic             done_q;

    logic [BCD_W-1:0] disp_bcd_q, disp_bcd_n;
    logic             disp_neg_q, disp_neg_n;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q, idx_d;
    logic             div_wrap;
    logic [DIGITS-1:0] an_q;
    logic [6:0]       seg_q;

    logic [3:0]       dig   [DIGITS];
    logic [6:0]       glyph [DIGITS];
    logic             neg_eff, ovf;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // ---------------- handshake FSM ----------------
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        latch      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    conv_start = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (conv_done) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                latch   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= latch;
            if (conv_start) begin
                neg_q <= neg;
            end
            disp_bcd_q <= disp_bcd_n;
            disp_neg_q <= disp_neg_n;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    // The glyph registers are fed from the display value being written this
    // edge, so new digits reach an/seg on the same edge the display latches.
    assign disp_bcd_n = latch ? conv_bcd : disp_bcd_q;
    assign disp_neg_n = latch ? neg_q    : disp_neg_q;

    // ---------------- composition ----------------
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig[i]   = disp_bcd_n[4*i +: 4];
            glyph[i] = bcd_to_seg(disp_bcd_n[4*i +: 4]);
        end
        // Negative zero shows as plain zero.
        neg_eff = disp_neg_n && (disp_bcd_n != '0);
        // Magnitudes are at most 1023, so a non-zero thousands digit means > 999.
        ovf     = neg_eff && (dig[3] != 4'd0);

`ifdef SEG_SCAN_BLANK_EN
        if (dig[3] == 4'd0) begin
            glyph[3] = SEG_BLANK;
            if (dig[2] == 4'd0) begin
                glyph[2] = SEG_BLANK;
                if (dig[1] == 4'd0) begin
                    glyph[1] = SEG_BLANK;
                end
            end
        end
        // Non-overflow negatives have a zero thousands digit; the sign sits
        // just left of the most significant shown digit.
        if (neg_eff && !ovf) begin
            if (dig[2] != 4'd0) begin
                glyph[3] = SEG_MINUS;
            end else if (dig[1] != 4'd0) begin
                glyph[2] = SEG_MINUS;
            end else begin
                glyph[1] = SEG_MINUS;
            end
        end
`else
        if (neg_eff && !ovf) begin
            glyph[3] = SEG_MINUS;
        end
`endif
        if (ovf) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                glyph[i] = SEG_MINUS;
            end
        end
    end

    // ---------------- scanner ----------------
    assign div_wrap = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign idx_d    = div_wrap ? idx_q + 2'd1 : idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1110;
            seg_q <= bcd_to_seg(4'd0);
        end else begin
            div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
            idx_q <= idx_d;
            an_q  <= ~(4'b0001 << idx_d);
            seg_q <= glyph[idx_d];
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with REFRESH_DIV=4. Expected glyphs are
// written out by hand; SEG_SCAN_BLANK_EN selects the blanked expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef SEG_SCAN_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [9:0] value;
    logic       neg;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .neg   (neg),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .seg   (seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge right after reset release.
    task automatic check_scan_from_reset(input string tag);
        logic [3:0] ea;
        logic [6:0] eg;
        for (int t = 0; t < 16; t++) begin
            ea = ~(4'b0001 << ((t / 4) % 4));
            eg = ((t / 4) % 4 == 0) ? S0 : LZ;
            check({tag, "_an"},   32'(an),   32'(ea));
            check({tag, "_seg"},  32'(seg),  32'(eg));
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_done"}, 32'(done), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] e [4];
        int idx;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            check({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                check({tag, "_seg"}, 32'(seg), 32'(e[idx]));
            end
        end
    endtask

    // Drive load for one edge; returns at the negedge after that edge.
    task automatic issue(input logic [9:0] v, input logic n);
        load  = 1'b1;
        value = v;
        neg   = n;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Counts busy samples from now until it drops; leaves time at the done cycle.
    task automatic wait_done(input string tag, input int exp_len);
        int nb = 0;
        while (busy && nb < 40) begin
            nb++;
            check({tag, "_no_early_done"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(nb),   32'(exp_len));
        check({tag, "_done"},     32'(done), 32'd1);
    endtask

    task automatic run_load(input string tag, input logic [9:0] v, input logic n);
        @(negedge clk);
        issue(v, n);
        wait_done(tag, 11);
        @(negedge clk);
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        neg   = 1'b0;
        #23;
        check("rst_an",   32'(an),   32'(4'b1110));
        check("rst_seg",  32'(seg),  32'(S0));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_scan_from_reset("scan");

        run_load("l1023", 10'd1023, 1'b0);
        check_display("d1023", S1, S0, S2, S3);

        run_load("lm42", 10'd42, 1'b1);
`ifdef SEG_SCAN_BLANK_EN
        check_display("dm42", SB, SM, S4, S2);
`else
        check_display("dm42", SM, S0, S4, S2);
`endif

        run_load("lm1000", 10'd1000, 1'b1);
        check_display("dm1000", SM, SM, SM, SM);

        run_load("lm5", 10'd5, 1'b1);
`ifdef SEG_SCAN_BLANK_EN
        check_display("dm5", SB, SB, SM, S5);
`else
        check_display("dm5", SM, S0, S0, S5);
`endif

        run_load("lm0", 10'd0, 1'b1);
        check_display("dm0", LZ, LZ, LZ, S0);

        // 500, then a dropped load of 7 three cycles later, then 8 in the done cycle.
        @(negedge clk);
        issue(10'd500, 1'b0);
        @(negedge clk);
        @(negedge clk);
        issue(10'd7, 1'b0);
        wait_done("l500", 8);
        issue(10'd8, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("l8", 11);
        @(negedge clk);
        check("l8_done_once", 32'(done), 32'd0);
        check_display("d8", LZ, LZ, LZ, S8);

        // Reset during the fifth SHIFT cycle of a 999 conversion.
        @(negedge clk);
        issue(10'd999, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_an",   32'(an),   32'(4'b1110));
        check("mid_rst_seg",  32'(seg),  32'(S0));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_scan_from_reset("rescan");
        check_display("d_after_rst", LZ, LZ, LZ, S0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
